// File: rtl/reset_sequencer.sv
// Reset sequencer for a two-domain system clocked from a PLL.
// Holds the video and CPU domains in reset until the PLL has been locked
// long enough. It then releases video first and the CPU a fixed delay
// later. It can pulse the CPU domain alone on request, and it drops back
// to full reset whenever lock is lost.

module reset_sequencer #(
  parameter int unsigned LOCK_CYCLES = 1024,
  parameter int unsigned CPU_DELAY   = 256,
  parameter int unsigned SOFT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic locked,
  input  logic soft_req,
  output logic video_reset,
  output logic cpu_reset,
  output logic ready
);

  localparam logic [1:0] WAIT_LOCK = 2'd0;
  localparam logic [1:0] VIDEO_UP  = 2'd1;
  localparam logic [1:0] RUN       = 2'd2;
  localparam logic [1:0] SOFT      = 2'd3;

  localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYCLES - 1);
  localparam logic [15:0] CPU_LAST  = 16'(CPU_DELAY - 1);
  localparam logic [15:0] SOFT_LAST = 16'(SOFT_CYCLES - 1);

  logic        locked_meta_q, locked_meta_d;
  logic        locked_s_q, locked_s_d;
  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        video_reset_q, video_reset_d;
  logic        cpu_reset_q, cpu_reset_d;
  logic        ready_q, ready_d;

  // Two-flop synchronizer for the asynchronous PLL lock flag
  always_comb begin
    locked_meta_d = locked;
    locked_s_d    = locked_meta_q;
  end

  // Sequencing FSM: lock loss beats soft requests and counter terminals
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        if (!locked_s_q) begin
          cnt_d = 16'd0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = VIDEO_UP;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      VIDEO_UP: begin
        if (!locked_s_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = 16'd0;
        end else if (cnt_q == CPU_LAST) begin
          state_d = RUN;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RUN: begin
        if (!locked_s_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = 16'd0;
        end else if (soft_req) begin
          state_d = SOFT;
          cnt_d   = 16'd0;
        end
      end
      SOFT: begin
        if (!locked_s_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = 16'd0;
        end else if (soft_req) begin
          cnt_d = 16'd0;
        end else if (cnt_q == SOFT_LAST) begin
          state_d = RUN;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // Resets assert on the edge that enters a reset state. Leaving WAIT_LOCK
  // or VIDEO_UP releases one edge later, so video falls LOCK_CYCLES+2 edges
  // after lock is first sampled and the CPU follows CPU_DELAY edges behind.
  // Because the CPU release can never come earlier than the video release,
  // the ordering between the two domains is preserved.
  always_comb begin
    video_reset_d = (state_d == WAIT_LOCK) || (state_q == WAIT_LOCK);
    cpu_reset_d   = (state_d != RUN) || (state_q == VIDEO_UP);
    ready_d       = !video_reset_d && !cpu_reset_d;
  end

  // State and output registers, all forced to the reset values asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      locked_meta_q <= 1'b0;
      locked_s_q    <= 1'b0;
      state_q       <= WAIT_LOCK;
      cnt_q         <= 16'd0;
      video_reset_q <= 1'b1;
      cpu_reset_q   <= 1'b1;
      ready_q       <= 1'b0;
    end else begin
      locked_meta_q <= locked_meta_d;
      locked_s_q    <= locked_s_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      video_reset_q <= video_reset_d;
      cpu_reset_q   <= cpu_reset_d;
      ready_q       <= ready_d;
    end
  end

  assign video_reset = video_reset_q;
  assign cpu_reset   = cpu_reset_q;
  assign ready       = ready_q;

endmodule
